param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//   Single-clock FIFO with configurable width and depth, for buffering byte/word streams inside one clock domain.
//   Builds on the two-clock 8x8 FIFO by adding:
//   - selectable standard or first-word-fall-through (FWFT) read mode;
//   - occupancy count and programmable almost-full / almost-empty flags;
//   - sticky overflow/underflow error flags and a synchronous flush.
// PARAMETERS
//   DATA_WIDTH  8  width of dataIn/dataOut in bits (>=1)
//   DEPTH       8  number of entries; power of two, >=2
//   ADDR_W      $clog2(DEPTH)  derived, not overridden
//   AF_TH       6  almostFull asserts when count >= AF_TH (1..DEPTH)
//   AE_TH       1  almostEmpty asserts when count <= AE_TH (0..DEPTH-1)
//   FWFT        0  0 = standard read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//   Clk          in   1           single clock, rising edge
//   reset        in   1           asynchronous, active-high
//   flush        in   1           synchronous clear of pointers/count
//   wrEn         in   1           write request
//   dataIn       in   DATA_WIDTH  write data
//   full         out  1           no free entry
//   almostFull   out  1           count >= AF_TH
//   rdEn         in   1           read request (FWFT: pop head word)
//   dataOut      out  DATA_WIDTH  read data
//   dataValid    out  1           dataOut holds a valid word
//   empty        out  1           no stored entry
//   almostEmpty  out  1           count <= AE_TH
//   count        out  ADDR_W+1    entries stored, 0..DEPTH
//   overflow     out  1           sticky: write attempted while full
//   underflow    out  1           sticky: read attempted while empty
//   clearErr     in   1           clears overflow/underflow
// BEHAVIOUR
//   Reset values:
//   - Pointers = 0; count = 0; full = 0; empty = 1; almostFull = 0; almostEmpty = 1.
//   - dataOut = 0; dataValid = 0; overflow = 0; underflow = 0.
//   - Memory contents are not reset.
//   Pointers are binary and ADDR_W+1 bits wide; low ADDR_W bits address memory. Wrap-around is by natural overflow.
//   - Full: MSBs differ and the low bits are equal.
//   - Empty: pointers are equal.
//   - All flags and count are registered and derived from the pointers.
//   Write accept = wrEn & !full & !flush:
//   - mem[wrPtr] <= dataIn; wrPtr += 1.
//   - wrEn & full: data dropped, overflow <= 1.
//   Read accept = rdEn & !empty & !flush:
//   - rdPtr += 1.
//   - rdEn & empty: underflow <= 1, pointers unchanged.
//   Simultaneous accepted read and write: count is unchanged.
//   - When full: the read is accepted and the write is rejected (overflow set). A write is never accepted in the same cycle as a full flag.
//   - When empty: the write is accepted and the read is rejected (underflow set).
//   Mode FWFT=0:
//   - On an accepted read, dataOut <= mem[rdPtr] at that edge and dataValid = 1 for exactly one cycle.
//   - Otherwise dataValid = 0 and dataOut holds its value.
//   Mode FWFT=1:
//   - dataOut = mem[rdPtr] combinationally; dataValid = !empty.
//   - rdEn while dataValid consumes the shown word; the next word appears after that edge.
//   Latency:
//   - A write at edge N clears empty after edge N.
//   - FWFT: the word is visible on dataOut after edge N.
//   - Standard: the earliest rdEn is at edge N+1, with data after edge N+1.
//   count = wrPtr - rdPtr, modulo 2^(ADDR_W+1). count == DEPTH exactly when full.
//   flush (synchronous, highest priority after reset):
//   - Pointers and count go to 0; empty = 1; dataValid = 0.
//   - A coincident wrEn/rdEn is ignored and does not set an error flag.
//   clearErr clears both sticky flags. A new error event in the same cycle wins and the flag stays 1.
//   Reset asserted mid-operation: all state returns to reset values immediately, independent of Clk.
// TESTING (DEPTH=8, DATA_WIDTH=8, AF_TH=6, AE_TH=1)
//   1. Write 0x01..0x08 -> full=1, count=8, almostFull from count 6. Read 8 (FWFT=0) -> 0x01..0x08 in order, each 1 cycle after rdEn; empty=1.
//   2. Full, wrEn with 0xAA -> dropped, overflow=1 stays set. clearErr -> 0. Empty rdEn -> underflow=1, count stays 0.
//   3. Run 20 writes and 20 reads interleaved across a pointer wrap -> order preserved; count never exceeds 8; full/empty exact at the boundaries.
//   4. count=4, wrEn & rdEn for 10 cycles -> count stays 4, data order preserved. At full, both -> read ok, write rejected, overflow=1.
//   5. FWFT=1: write 0x5A into empty -> dataOut=0x5A, dataValid=1 next cycle with no rdEn. rdEn -> empty=1, dataValid=0.
//   6. count=5, flush with wrEn=1 -> count=0, empty=1, no error. Async reset mid-burst -> all outputs at reset values before the next Clk edge.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through reads, occupancy
// flags, sticky overflow/underflow error flags and a synchronous flush.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 1,
    parameter int FWFT       = 0,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic                  full,
    output logic                  almostFull,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  empty,
    output logic                  almostEmpty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clearErr
);

    localparam logic [ADDR_W:0] AF_V = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_V = (ADDR_W+1)'(AE_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  wr_acc, rd_acc;
    logic [ADDR_W-1:0]     rd_addr;

    assign rd_addr = rd_ptr_q[ADDR_W-1:0];

    // A request is accepted only against the registered flags of this cycle:
    // wrEn is taken when !full, rdEn when !empty, and flush overrides both.
    always_comb begin
        wr_acc   = wrEn & ~full_q & ~flush;
        rd_acc   = rdEn & ~empty_q & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_d = flush ? '0 : rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                   (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        af_d     = (count_d >= AF_V);
        ae_d     = (count_d <= AE_V);
        ovf_d    = (wrEn & full_q & ~flush) | (ovf_q & ~clearErr);
        unf_d    = (rdEn & empty_q & ~flush) | (unf_q & ~clearErr);
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        if (rd_acc) begin
            dout_d   = mem_q[rd_addr];
            dvalid_d = 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= dataIn;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    // FWFT exposes the head word directly; it reads as zero while empty.
    generate
        if (FWFT != 0) begin : g_fwft
            assign dataOut   = empty_q ? '0 : mem_q[rd_addr];
            assign dataValid = ~empty_q;
        end else begin : g_std
            assign dataOut   = dout_q;
            assign dataValid = dvalid_q;
        end
    endgenerate

    assign full        = full_q;
    assign empty       = empty_q;
    assign almostFull  = af_q;
    assign almostEmpty = ae_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-read instance checked cycle by cycle
// against a queue model, plus a first-word-fall-through instance.
module tb_param_sync_fifo;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       s_flush, s_wrEn, s_rdEn, s_clearErr;
    logic [7:0] s_dataIn, s_dout;
    logic       s_full, s_af, s_empty, s_ae, s_dv, s_ovf, s_unf;
    logic [3:0] s_count;

    logic       f_flush, f_wrEn, f_rdEn, f_clearErr;
    logic [7:0] f_dataIn, f_dout;
    logic       f_full, f_af, f_empty, f_ae, f_dv, f_ovf, f_unf;
    logic [3:0] f_count;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_TH(6), .AE_TH(1), .FWFT(0)) dut_std (
        .Clk(clk), .reset(reset), .flush(s_flush), .wrEn(s_wrEn), .dataIn(s_dataIn),
        .full(s_full), .almostFull(s_af), .rdEn(s_rdEn), .dataOut(s_dout),
        .dataValid(s_dv), .empty(s_empty), .almostEmpty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clearErr(s_clearErr)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_TH(6), .AE_TH(1), .FWFT(1)) dut_fwft (
        .Clk(clk), .reset(reset), .flush(f_flush), .wrEn(f_wrEn), .dataIn(f_dataIn),
        .full(f_full), .almostFull(f_af), .rdEn(f_rdEn), .dataOut(f_dout),
        .dataValid(f_dv), .empty(f_empty), .almostEmpty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clearErr(f_clearErr)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] f_exp_q[$];
    int         m_cnt;
    bit         m_ovf, m_unf;
    logic [7:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_std();
        chk("count", s_count, m_cnt);
        chk("full", s_full, m_cnt == DEPTH);
        chk("empty", s_empty, m_cnt == 0);
        chk("almostFull", s_af, m_cnt >= 6);
        chk("almostEmpty", s_ae, m_cnt <= 1);
        chk("overflow", s_ovf, m_ovf);
        chk("underflow", s_unf, m_unf);
        chk("dataOut", s_dout, m_dout);
    endtask

    // One clock of the standard instance, with the model advanced alongside.
    task automatic cycle(input bit we, input logic [7:0] wd, input bit re,
                         input bit ce, input bit fl);
        bit wacc, racc;
        s_wrEn = we; s_dataIn = wd; s_rdEn = re; s_clearErr = ce; s_flush = fl;
        wacc  = we && (m_cnt < DEPTH) && !fl;
        racc  = re && (m_cnt > 0) && !fl;
        m_ovf = (we && m_cnt == DEPTH && !fl) || (m_ovf && !ce);
        m_unf = (re && m_cnt == 0 && !fl) || (m_unf && !ce);
        if (racc) m_dout = exp_q.pop_front();
        if (wacc) exp_q.push_back(wd);
        if (fl) exp_q.delete();
        m_cnt = exp_q.size();
        @(posedge clk); #1;
        s_wrEn = 0; s_rdEn = 0; s_clearErr = 0; s_flush = 0;
        chk("dataValid", s_dv, racc);
        chk_all_std();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && exp_q.size() > 0; i++) cycle(0, 8'h00, 1, 0, 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt = 0; m_ovf = 0; m_unf = 0; m_dout = '0;
    endtask

    int nw, nr;
    bit rwe, rre;

    initial begin
        reset = 1;
        s_flush = 0; s_wrEn = 0; s_rdEn = 0; s_clearErr = 0; s_dataIn = '0;
        f_flush = 0; f_wrEn = 0; f_rdEn = 0; f_clearErr = 0; f_dataIn = '0;
        model_reset();
        #12 reset = 0;
        @(posedge clk); #1;

        // reset values
        chk("rst_dataValid", s_dv, 0);
        chk_all_std();
        chk("rst_f_dv", f_dv, 0);
        chk("rst_f_empty", f_empty, 1);
        chk("rst_f_count", f_count, 0);

        // fill to full, then read back in order
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0, 0);

        // overflow / clearErr / underflow
        for (int i = 0; i < 8; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 0, 0);
        cycle(1, 8'hAA, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        drain();
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);

        // 20 writes and 20 reads interleaved across a pointer wrap
        nw = 0; nr = 0;
        for (int i = 0; i < 400 && (nw < 20 || nr < 20); i++) begin
            rwe = (nw < 20) && ($urandom_range(0, 1) == 1);
            rre = (nr < 20) && ($urandom_range(0, 1) == 1);
            if (rwe && m_cnt < DEPTH) nw++;
            if (rre && m_cnt > 0) nr++;
            cycle(rwe, 8'($urandom_range(0, 255)), rre, 0, 0);
        end
        chk("wrap_done", (nw == 20) && (nr == 20), 1);
        drain();
        cycle(0, 8'h00, 0, 1, 0);

        // steady simultaneous read/write at count 4, then both at full
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 8'($urandom_range(0, 255)), 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h70 + i), 0, 0, 0);
        cycle(1, 8'hBB, 1, 0, 0);
        drain();
        cycle(0, 8'h00, 0, 1, 0);

        // FWFT instance
        f_wrEn = 1; f_dataIn = 8'h5A;
        @(posedge clk); #1;
        f_wrEn = 0;
        chk("fwft_dout", f_dout, 8'h5A);
        chk("fwft_dv", f_dv, 1);
        chk("fwft_empty", f_empty, 0);
        @(posedge clk); #1;
        chk("fwft_hold", f_dout, 8'h5A);
        f_rdEn = 1;
        @(posedge clk); #1;
        f_rdEn = 0;
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_dv", f_dv, 0);
        chk("fwft_pop_unf", f_unf, 0);
        for (int i = 0; i < 3; i++) begin
            f_wrEn = 1; f_dataIn = 8'($urandom_range(0, 255));
            f_exp_q.push_back(f_dataIn);
            @(posedge clk); #1;
        end
        f_wrEn = 0;
        chk("fwft_count", f_count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("fwft_head_dv", f_dv, 1);
            chk("fwft_head", f_dout, f_exp_q.pop_front());
            f_rdEn = 1;
            @(posedge clk); #1;
            f_rdEn = 0;
        end
        chk("fwft_end_empty", f_empty, 1);

        // flush with coincident write, then async reset mid-burst
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h20 + i), 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h90 + i), 0, 0, 0);
        cycle(1, 8'hC3, 1, 0, 0);
        s_wrEn = 1; s_rdEn = 1; s_dataIn = 8'hEE;
        #2 reset = 1;
        #1;
        model_reset();
        chk("arst_dataValid", s_dv, 0);
        chk_all_std();
        chk("arst_f_dv", f_dv, 0);
        #2 reset = 0;
        s_wrEn = 0; s_rdEn = 0;
        cycle(1, 8'h61, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
